// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expander: word-serial key load, then one expanded
// word per cycle into a round-key store that is read by (round, word).
module aes_key_schedule #(
   parameter int MAX_NK = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  key_size,
   input  logic        key_valid,
   input  logic [31:0] key_word,
   output logic        key_ready,
   input  logic [3:0]  rd_round,
   input  logic [1:0]  rd_word,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // state   | meaning
   // S_IDLE  | waiting for start
   // S_LOAD  | accepting Nk key words
   // S_EXPAND| generating w[Nk..T-1], one per cycle
   // S_DONE  | all round keys valid
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

   localparam int DEPTH = 4 * (MAX_NK + 7);

   state_t                state_q, state_d;
   logic [3:0]            nk_q, nk_d;
   logic [5:0]            i_q, i_d;
   logic [2:0]            wrap_q, wrap_d;
   logic [7:0]            rcon_q, rcon_d;
   logic [MAX_NK*32-1:0]  win_q, win_d;
   logic                  err_q, err_d;
   logic [31:0]           rd_data_q, rd_data_d;
   logic [31:0]           store_q [DEPTH];

   logic        wr_en;
   logic [31:0] wr_data;
   logic [3:0]  nk_req;
   logic        start_ok;
   logic [5:0]  t_last;
   logic [31:0] prev_w, old_w, sub_in, sub_out, temp_w, w_new;
   logic [3:0]  nr;
   logic [5:0]  rd_addr;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   assign nk_req   = {1'b0, key_size, 1'b0} + 4'd4;
   assign start_ok = start && (key_size != 2'd3) && (nk_req <= 4'(MAX_NK));
   assign t_last   = {nk_q, 2'b00} + 6'd27;

   // Window holds the last Nk words, newest in the low 32 bits.
   always_comb begin
      prev_w = win_q[31:0];
      old_w  = '0;
      for (int k = 0; k < MAX_NK; k++) begin
         if (nk_q == 4'(k + 1)) old_w = win_q[k*32 +: 32];
      end
      sub_in  = (wrap_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
      sub_out = sub_word(sub_in);
      temp_w  = prev_w;
      if (wrap_q == 3'd0)
         temp_w = sub_out ^ {rcon_q, 24'h0};
      else if (nk_q == 4'd8 && wrap_q == 3'd4)
         temp_w = sub_out;
      w_new = old_w ^ temp_w;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         nk_q      <= 4'd4;
         i_q       <= '0;
         wrap_q    <= '0;
         rcon_q    <= 8'h01;
         win_q     <= '0;
         err_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         nk_q      <= nk_d;
         i_q       <= i_d;
         wrap_q    <= wrap_d;
         rcon_q    <= rcon_d;
         win_q     <= win_d;
         err_q     <= err_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) store_q[i_q] <= wr_data;
   end

   always_comb begin
      state_d = state_q;
      nk_d    = nk_q;
      i_d     = i_q;
      wrap_d  = wrap_q;
      rcon_d  = rcon_q;
      win_d   = win_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      wr_data = w_new;
      if (start) begin
         if (start_ok) begin
            state_d = S_LOAD;
            nk_d    = nk_req;
            i_d     = '0;
            wrap_d  = '0;
            rcon_d  = 8'h01;
         end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
         end
      end else begin
         case (state_q)
            S_LOAD: begin
               if (key_valid) begin
                  wr_en   = 1'b1;
                  wr_data = key_word;
                  i_d     = i_q + 6'd1;
                  if (i_q == {2'b00, nk_q} - 6'd1) state_d = S_EXPAND;
               end
            end
            S_EXPAND: begin
               wr_en  = 1'b1;
               i_d    = i_q + 6'd1;
               wrap_d = ({1'b0, wrap_q} == nk_q - 4'd1) ? 3'd0 : wrap_q + 3'd1;
               if (wrap_q == 3'd0)
                  rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
               if (i_q == t_last) state_d = S_DONE;
            end
            default: ;
         endcase
      end
      if (wr_en) win_d = {win_q[(MAX_NK-1)*32-1:0], wr_data};
   end

   always_comb begin
      nr        = nk_q + 4'd6;
      rd_addr   = {rd_round, 2'b00} + {4'b0000, rd_word};
      rd_data_d = (rd_round > nr) ? 32'h0 : store_q[rd_addr];
   end

   always_comb begin
      key_ready = (state_q == S_LOAD);
      busy      = (state_q == S_LOAD) || (state_q == S_EXPAND);
      done      = (state_q == S_DONE);
   end

   assign err     = err_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 vectors plus random keys against a reference
// expander built from a table-generated S-box; a second MAX_NK=4 instance checks limits.
module tb_aes_key_schedule;
   logic        clk = 1'b0;
   logic        reset, start, key_valid;
   logic [1:0]  key_size;
   logic [31:0] key_word;
   logic [3:0]  rd_round;
   logic [1:0]  rd_word;
   logic        key_ready, busy, done, err;
   logic [31:0] rd_data;
   logic        key_ready4, busy4, done4, err4;
   logic [31:0] rd_data4;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  sbox [256];
   logic [31:0] mkey [8];
   logic [31:0] mw   [60];

   aes_key_schedule #(.MAX_NK(8)) dut (
      .clk(clk), .reset(reset), .start(start), .key_size(key_size),
      .key_valid(key_valid), .key_word(key_word), .key_ready(key_ready),
      .rd_round(rd_round), .rd_word(rd_word), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err));

   aes_key_schedule #(.MAX_NK(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .key_size(key_size),
      .key_valid(key_valid), .key_word(key_word), .key_ready(key_ready4),
      .rd_round(rd_round), .rd_word(rd_word), .rd_data(rd_data4),
      .busy(busy4), .done(done4), .err(err4));

   always #5 clk = ~clk;

   // S-box from the generator/inverse walk: p steps by *3, q by /3, so q = p^-1.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
   endtask

   function automatic logic [31:0] m_sub(input logic [31:0] x);
      return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
   endfunction

   task automatic model_expand(input int nk);
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) mw[i] = mkey[i];
      for (int i = nk; i < 4 * (nk + 7); i++) begin
         tmp = mw[i-1];
         if (i % nk == 0) begin
            tmp = m_sub({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % nk == 4) begin
            tmp = m_sub(tmp);
         end
         mw[i] = mw[i-nk] ^ tmp;
      end
   endtask

   task automatic set_fips_key(input int ks);
      case (ks)
         0: begin
            mkey[0] = 32'h2b7e1516; mkey[1] = 32'h28aed2a6;
            mkey[2] = 32'habf71588; mkey[3] = 32'h09cf4f3c;
         end
         1: begin
            mkey[0] = 32'h8e73b0f7; mkey[1] = 32'hda0e6452; mkey[2] = 32'hc810f32b;
            mkey[3] = 32'h809079e5; mkey[4] = 32'h62f8ead2; mkey[5] = 32'h522c6b7b;
         end
         default: begin
            mkey[0] = 32'h603deb10; mkey[1] = 32'h15ca71be; mkey[2] = 32'h2b73aef0;
            mkey[3] = 32'h857d7781; mkey[4] = 32'h1f352c07; mkey[5] = 32'h3b6108d7;
            mkey[6] = 32'h2d9810a3; mkey[7] = 32'h0914dff4;
         end
      endcase
   endtask

   // Stimulus only: start (with a stray key_valid that must not transfer), load words
   // with optional gaps, then count EXPAND cycles until done or abort point.
   task automatic drive_load(input int ks, input int gap_max, input int abort_at,
                             output int cyc, output bit timed_out);
      int nk;
      nk = 4 + 2 * ks;
      @(negedge clk);
      start = 1'b1; key_size = 2'(ks); key_valid = 1'b1; key_word = 32'hdeadbeef;
      @(negedge clk);
      start = 1'b0; key_valid = 1'b0;
      for (int w = 0; w < nk; w++) begin
         if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
         key_valid = 1'b1; key_word = mkey[w];
         @(negedge clk);
         key_valid = 1'b0;
      end
      cyc = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         if (abort_at > 0 && cyc == abort_at) break;
         if (busy && !key_ready) cyc++;
         @(negedge clk);
      end
      timed_out = (abort_at == 0) && !done;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; key_size = 2'd0; key_valid = 1'b0;
      key_word = '0; rd_round = '0; rd_word = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
      n_checks++; if (key_ready !== 1'b0) $display("FAIL reset_key_ready got %b want 0", key_ready); else n_pass++;
      n_checks++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h want 0", rd_data); else n_pass++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fips(input int ks, input int r1, input int w1, input logic [31:0] v1,
                            input int r2, input int w2, input logic [31:0] v2);
      int nk, cyc;
      bit to;
      nk = 4 + 2 * ks;
      set_fips_key(ks);
      model_expand(nk);
      drive_load(ks, 0, 0, cyc, to);
      n_checks++; if (to) $display("FAIL fips%0d_timeout done never rose", ks); else n_pass++;
      n_checks++; if (cyc != 4 * (nk + 7) - nk) $display("FAIL fips%0d_expand_cycles got %0d want %0d", ks, cyc, 4 * (nk + 7) - nk); else n_pass++;
      for (int a = 0; a < 4 * (nk + 7); a++) begin
         rd_round = 4'(a / 4); rd_word = 2'(a % 4);
         @(negedge clk);
         n_checks++; if (rd_data !== mw[a]) $display("FAIL fips%0d_word[%0d] got %h want %h", ks, a, rd_data, mw[a]); else n_pass++;
         if (ks == 0) begin
            n_checks++; if (rd_data4 !== mw[a]) $display("FAIL max4_word[%0d] got %h want %h", a, rd_data4, mw[a]); else n_pass++;
         end
      end
      rd_round = 4'(r1); rd_word = 2'(w1);
      @(negedge clk);
      n_checks++; if (rd_data !== v1) $display("FAIL fips%0d_vec1 got %h want %h", ks, rd_data, v1); else n_pass++;
      rd_round = 4'(r2); rd_word = 2'(w2);
      @(negedge clk);
      n_checks++; if (rd_data !== v2) $display("FAIL fips%0d_vec2 got %h want %h", ks, rd_data, v2); else n_pass++;
      rd_round = 4'(nk + 7); rd_word = 2'd0;
      @(negedge clk);
      n_checks++; if (rd_data !== 32'h0) $display("FAIL fips%0d_round_oob got %h want 0", ks, rd_data); else n_pass++;
   endtask

   task automatic test_max_nk_limit();
      @(negedge clk);
      start = 1'b1; key_size = 2'd2;
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (err4 !== 1'b1) $display("FAIL max4_err_pulse got %b want 1", err4); else n_pass++;
      n_checks++; if (busy4 !== 1'b0) $display("FAIL max4_busy got %b want 0", busy4); else n_pass++;
      @(negedge clk);
      n_checks++; if (err4 !== 1'b0) $display("FAIL max4_err_width got %b want 0", err4); else n_pass++;
      n_checks++; if (busy4 !== 1'b0) $display("FAIL max4_busy_after got %b want 0", busy4); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL max8_accepts_256 busy got %b want 1", busy); else n_pass++;
   endtask

   task automatic test_handshake();
      int cyc;
      bit to;
      set_fips_key(0);
      model_expand(4);
      drive_load(0, 3, 0, cyc, to);
      n_checks++; if (to) $display("FAIL hs_timeout done never rose"); else n_pass++;
      n_checks++; if (cyc != 40) $display("FAIL hs_expand_cycles got %0d want 40", cyc); else n_pass++;
      n_checks++; if (key_ready !== 1'b0) $display("FAIL hs_key_ready_done got %b want 0", key_ready); else n_pass++;
      for (int a = 0; a < 44; a++) begin
         rd_round = 4'(a / 4); rd_word = 2'(a % 4);
         @(negedge clk);
         n_checks++; if (rd_data !== mw[a]) $display("FAIL hs_word[%0d] got %h want %h", a, rd_data, mw[a]); else n_pass++;
      end
   endtask

   task automatic test_random_keys();
      int ks, nk, cyc;
      bit to;
      for (int rep = 0; rep < 6; rep++) begin
         ks = rep % 3;
         nk = 4 + 2 * ks;
         for (int w = 0; w < 8; w++) mkey[w] = $urandom;
         model_expand(nk);
         drive_load(ks, (rep % 2 == 1) ? 2 : 0, 0, cyc, to);
         n_checks++; if (to) $display("FAIL rnd%0d_timeout done never rose", rep); else n_pass++;
         n_checks++; if (cyc != 4 * (nk + 7) - nk) $display("FAIL rnd%0d_expand_cycles got %0d want %0d", rep, cyc, 4 * (nk + 7) - nk); else n_pass++;
         for (int a = 0; a < 4 * (nk + 7); a++) begin
            rd_round = 4'(a / 4); rd_word = 2'(a % 4);
            @(negedge clk);
            n_checks++; if (rd_data !== mw[a]) $display("FAIL rnd%0d_word[%0d] got %h want %h", rep, a, rd_data, mw[a]); else n_pass++;
         end
      end
   endtask

   task automatic test_abort();
      int cyc;
      bit to;
      set_fips_key(2);
      drive_load(2, 0, 10, cyc, to);
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL abort_mid_expand busy %b done %b want 1 0", busy, done); else n_pass++;
      set_fips_key(0);
      model_expand(4);
      drive_load(0, 0, 0, cyc, to);
      n_checks++; if (to || cyc != 40) $display("FAIL abort_rerun cycles got %0d want 40", cyc); else n_pass++;
      for (int a = 0; a < 44; a++) begin
         rd_round = 4'(a / 4); rd_word = 2'(a % 4);
         @(negedge clk);
         n_checks++; if (rd_data !== mw[a]) $display("FAIL abort_word[%0d] got %h want %h", a, rd_data, mw[a]); else n_pass++;
      end
      n_checks++; if (done !== 1'b1) $display("FAIL abort_done_before_illegal got %b want 1", done); else n_pass++;
      start = 1'b1; key_size = 2'd3;
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (err !== 1'b1) $display("FAIL illegal_err got %b want 1", err); else n_pass++;
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL illegal_state done %b busy %b want 0 0", done, busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (err !== 1'b0) $display("FAIL illegal_err_width got %b want 0", err); else n_pass++;
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL illegal_idle done %b busy %b want 0 0", done, busy); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit to;
      set_fips_key(0);
      model_expand(4);
      drive_load(0, 0, 5, cyc, to);
      n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_pre_busy got %b want 1", busy); else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else n_pass++;
      n_checks++; if (rd_data !== 32'h0) $display("FAIL rstmid_rd_data got %h want 0", rd_data); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      drive_load(0, 0, 0, cyc, to);
      n_checks++; if (to || cyc != 40) $display("FAIL rstmid_rerun cycles got %0d want 40", cyc); else n_pass++;
      for (int a = 0; a < 44; a++) begin
         rd_round = 4'(a / 4); rd_word = 2'(a % 4);
         @(negedge clk);
         n_checks++; if (rd_data !== mw[a]) $display("FAIL rstmid_word[%0d] got %h want %h", a, rd_data, mw[a]); else n_pass++;
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips(0, 1, 0, 32'ha0fafe17, 10, 3, 32'hb6630ca6);
      test_fips(1, 1, 2, 32'hfe0c91f7, 12, 3, 32'h01002202);
      test_fips(2, 2, 0, 32'h9ba35411, 14, 3, 32'h706c631e);
      test_max_nk_limit();
      test_handshake();
      test_random_keys();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
